// File: rtl/adder_bcd.sv
// Registered one-digit decimal adder: sums two 4-bit operands into tens/units digits and flags non-BCD operands.
// Latency 1 cycle, one result per cycle; no backpressure, every in_valid cycle is accepted.
module adder_bcd (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] in0,
    input  logic [3:0] in1,
    output logic [3:0] out0,
    output logic [3:0] out1,
    output logic       out_valid,
    output logic       bcd_err
);

    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    // Assert asynchronously, release only after two clean edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    logic [4:0] sum;
    logic [4:0] rem;
    logic [1:0] tens;

    logic [3:0] out0_q, out0_d;
    logic [3:0] out1_q, out1_d;
    logic       err_q, err_d;
    logic       vld_q;

    assign sum = {1'b0, in0} + {1'b0, in1};

    // Compare-and-subtract decimal split; sum tops out at 30.
    always_comb begin
        tens = 2'd0;
        rem  = sum;
        if (sum >= 5'd30) begin
            tens = 2'd3;
            rem  = sum - 5'd30;
        end else if (sum >= 5'd20) begin
            tens = 2'd2;
            rem  = sum - 5'd20;
        end else if (sum >= 5'd10) begin
            tens = 2'd1;
            rem  = sum - 5'd10;
        end
    end

    always_comb begin
        out0_d = out0_q;
        out1_d = out1_q;
        err_d  = err_q;
        if (in_valid) begin
            out0_d = rem[3:0];
            out1_d = {2'b00, tens};
            err_d  = (in0 > 4'd9) | (in1 > 4'd9);
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            out0_q <= 4'd0;
            out1_q <= 4'd0;
            err_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            out0_q <= out0_d;
            out1_q <= out1_d;
            err_q  <= err_d;
            vld_q  <= in_valid;
        end
    end

    assign out0      = out0_q;
    assign out1      = out1_q;
    assign bcd_err   = err_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_adder_bcd.sv
// Self-checking bench for adder_bcd: vector table, exhaustive sweep, random traffic and reset corners.
module tb_adder_bcd;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in0;
    logic [3:0] in1;
    logic [3:0] out0;
    logic [3:0] out1;
    logic       out_valid;
    logic       bcd_err;

    int checks = 0;
    int errors = 0;

    adder_bcd dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in0       (in0),
        .in1       (in1),
        .out0      (out0),
        .out1      (out1),
        .out_valid (out_valid),
        .bcd_err   (bcd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int tens;
        int units;
        int err;
    } vec_t;

    vec_t vecs[7];

    // Reference model state: what the outputs should currently show.
    int m_tens, m_units, m_err, m_vld;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic model_capture(input int v, input int a, input int b);
        int s;
        s = a + b;
        m_vld = v;
        if (v != 0) begin
            m_tens  = s / 10;
            m_units = s % 10;
            m_err   = (a > 9 || b > 9) ? 1 : 0;
        end
    endtask

    task automatic check_model(input string name);
        check({name, ".out1"}, int'(out1), m_tens);
        check({name, ".out0"}, int'(out0), m_units);
        check({name, ".bcd_err"}, int'(bcd_err), m_err);
        check({name, ".out_valid"}, int'(out_valid), m_vld);
    endtask

    // Drive one cycle of inputs at the falling edge, sample 1ns after the rising edge.
    task automatic step(input int v, input int a, input int b);
        @(negedge clk);
        in_valid = v[0];
        in0      = a[3:0];
        in1      = b[3:0];
        @(posedge clk);
        #1;
        model_capture(v, a, b);
    endtask

    // Wait (bounded) for the first result after a reset release with in_valid held.
    task automatic wait_result(input string name, input int a, input int b);
        bit seen;
        seen = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        check({name, ".seen"}, int'(seen), 1);
        if (seen) begin
            model_capture(1, a, b);
            check_model(name);
        end
    endtask

    initial begin
        vecs[0] = '{0, 0, 0, 0, 0};
        vecs[1] = '{5, 4, 0, 9, 0};
        vecs[2] = '{5, 5, 1, 0, 0};
        vecs[3] = '{9, 9, 1, 8, 0};
        vecs[4] = '{14, 14, 2, 8, 1};
        vecs[5] = '{15, 15, 3, 0, 1};
        vecs[6] = '{10, 0, 1, 0, 1};

        m_tens = 0; m_units = 0; m_err = 0; m_vld = 0;

        // Reset with live operands on the inputs.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in0      = 4'd9;
        in1      = 4'd9;
        repeat (3) @(posedge clk);
        #1;
        check_model("reset");
        @(negedge clk);
        rst_n = 1'b1;
        wait_result("reset_release", 9, 9);

        // Fixed vectors, checked against the hand-written table.
        foreach (vecs[i]) begin
            step(1, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d.out1", i), int'(out1), vecs[i].tens);
            check($sformatf("vec%0d.out0", i), int'(out0), vecs[i].units);
            check($sformatf("vec%0d.err", i), int'(bcd_err), vecs[i].err);
            check($sformatf("vec%0d.vld", i), int'(out_valid), 1);
        end

        // Exhaustive sweep, back-to-back valid.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                step(1, a, b);
                check("sweep.sum", int'(out1) * 10 + int'(out0), a + b);
                check("sweep.units_le9", (out0 <= 4'd9) ? 1 : 0, 1);
                check("sweep.err", int'(bcd_err), (a > 9 || b > 9) ? 1 : 0);
                check("sweep.vld", int'(out_valid), 1);
            end
        end

        // Hold behaviour while idle.
        step(1, 7, 8);
        check_model("hold_capture");
        check("hold_capture.out1", int'(out1), 1);
        check("hold_capture.out0", int'(out0), 5);
        for (int i = 0; i < 5; i++) begin
            step(0, $urandom_range(15), $urandom_range(15));
            check("hold.out1", int'(out1), 1);
            check("hold.out0", int'(out0), 5);
            check("hold.vld", int'(out_valid), 0);
        end

        // Random traffic with random valid gaps.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(3) != 0) ? 1 : 0, $urandom_range(15), $urandom_range(15));
            check_model("random");
        end

        // Asynchronous reset pulse mid-stream.
        step(1, 9, 8);
        step(1, 6, 7);
        check_model("pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        m_tens = 0; m_units = 0; m_err = 0; m_vld = 0;
        check_model("async_reset");
        @(negedge clk);
        in_valid = 1'b1;
        in0      = 4'd3;
        in1      = 4'd4;
        rst_n    = 1'b1;
        wait_result("post_reset", 3, 4);
        step(1, 12, 9);
        check_model("post_reset_next");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
